// File: rtl/serial_word_loader_pkg.sv
// Shared definitions for the serial word loader and the load-enabled register it feeds.
package serial_word_loader_pkg;

   localparam int WORD_W = 4;

   // 2'd3 is never entered and is treated as IDLE by the decoder
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_STOP = 2'd2
   } state_t;

endpackage

// File: rtl/serial_word_loader.sv
// Purpose: deserialises start/WIDTH data (LSB first)/stop frames into a word for the downstream register.
// Latency: d and load update on the stop-bit sampling edge; frame_err pulses on that same edge.
// Backpressure: none; bit_en paces the line and any gap length between bits is held indefinitely.
module serial_word_loader
   import serial_word_loader_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_en,
   input  logic             rx,
   input  logic             clear,
   output logic [WIDTH-1:0] d,
   output logic             load,
   output logic             frame_err,
   output logic             busy
);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   sreg;
   logic               in_idle;
   logic               in_data;
   logic               in_stop;
   logic               load_nxt;
   logic               err_nxt;

   assign in_data = (state == ST_DATA);
   assign in_stop = (state == ST_STOP);
   assign in_idle = !in_data && !in_stop;
   assign busy    = !in_idle;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (clear) begin
         state_nxt = ST_IDLE;
      end else if (bit_en) begin
         case (state)
            ST_DATA: begin
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state_nxt = ST_STOP;
               end
            end
            // stop edge never doubles as a start edge
            ST_STOP: begin
               state_nxt = ST_IDLE;
               load_nxt  = rx;
               err_nxt   = !rx;
            end
            default: begin
               state_nxt = rx ? ST_IDLE : ST_DATA;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         sreg      <= '0;
         d         <= '0;
         load      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         load      <= load_nxt;
         frame_err <= err_nxt;
         if (load_nxt) begin
            d <= sreg;
         end
         if (clear) begin
            cnt <= '0;
         end else if (bit_en) begin
            if (in_idle && !rx) begin
               cnt <= '0;
            end else if (in_data) begin
               sreg[cnt] <= rx;
               cnt       <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule
